// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_ctrl_if                                                         |
// | Decode inputs, memory handshake and datapath controls of multicycle_ctrl.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface multicycle_ctrl_if;
  logic [5:0] Opcode;
  logic [5:0] Function_opcode;
  logic       Zero;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_we;
  logic       IR_write;
  logic       PC_write;
  logic [1:0] pc_src;
  logic [1:0] ALUOp;
  logic       ALUSrc;
  logic       I_format;
  logic       Sftmd;
  logic       Jal;
  logic       RegDST;
  logic       MemtoReg;
  logic       RegWrite;
  logic       retire;
  logic       illegal_insn;
  logic [2:0] state_o;

  modport master (
    input  Opcode, Function_opcode, Zero, mem_ack,
    output mem_req, mem_we, IR_write, PC_write, pc_src, ALUOp, ALUSrc,
           I_format, Sftmd, Jal, RegDST, MemtoReg, RegWrite, retire,
           illegal_insn, state_o
  );

  modport slave (
    output Opcode, Function_opcode, Zero, mem_ack,
    input  mem_req, mem_we, IR_write, PC_write, pc_src, ALUOp, ALUSrc,
           I_format, Sftmd, Jal, RegDST, MemtoReg, RegWrite, retire,
           illegal_insn, state_o
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_ctrl                                                            |
// | FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle MIPS core.          |
// | Option macro: CTRL_ILLEGAL_TRAP_EN (illegal opcode -> sticky TRAP state).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multicycle_ctrl (
  input  logic               clock,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  localparam logic [5:0] c_OP_R   = 6'b000000;
  localparam logic [5:0] c_OP_J   = 6'b000010;
  localparam logic [5:0] c_OP_JAL = 6'b000011;
  localparam logic [5:0] c_OP_BEQ = 6'b000100;
  localparam logic [5:0] c_OP_BNE = 6'b000101;
  localparam logic [5:0] c_OP_LW  = 6'b100011;
  localparam logic [5:0] c_OP_SW  = 6'b101011;
  localparam logic [5:0] c_FN_JR  = 6'b001000;

  state_t r_state;
  state_t w_next_state;

  logic w_is_r, w_is_jr, w_is_j, w_is_jal, w_is_beq, w_is_bne;
  logic w_is_ifmt, w_is_lw, w_is_sw, w_legal, w_alu_phase;

  logic       w_mem_req, w_mem_we, w_ir_write, w_pc_write;
  logic [1:0] w_pc_src, w_aluop;
  logic       w_alusrc, w_ifmt, w_sftmd, w_jal, w_regdst, w_memtoreg;
  logic       w_regwrite, w_retire;

  // The IR is stable from DECODE onward, so the decode can stay combinational.
  assign w_is_r    = (bus.Opcode == c_OP_R);
  assign w_is_jr   = w_is_r && (bus.Function_opcode == c_FN_JR);
  assign w_is_j    = (bus.Opcode == c_OP_J);
  assign w_is_jal  = (bus.Opcode == c_OP_JAL);
  assign w_is_beq  = (bus.Opcode == c_OP_BEQ);
  assign w_is_bne  = (bus.Opcode == c_OP_BNE);
  assign w_is_ifmt = (bus.Opcode[5:3] == 3'b001);
  assign w_is_lw   = (bus.Opcode == c_OP_LW);
  assign w_is_sw   = (bus.Opcode == c_OP_SW);
  assign w_legal   = w_is_r || w_is_j || w_is_jal || w_is_beq || w_is_bne ||
                     w_is_ifmt || w_is_lw || w_is_sw;

  assign w_alu_phase = (r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 2'b00;
    w_aluop      = 2'b00;
    w_alusrc     = 1'b0;
    w_ifmt       = 1'b0;
    w_sftmd      = 1'b0;
    w_jal        = 1'b0;
    w_regdst     = 1'b0;
    w_memtoreg   = 1'b0;
    w_regwrite   = 1'b0;
    w_retire     = 1'b0;

    if (w_alu_phase) begin
      w_aluop  = {w_is_r || w_is_ifmt, w_is_beq || w_is_bne};
      w_alusrc = w_is_ifmt || w_is_lw || w_is_sw;
      w_ifmt   = w_is_ifmt;
      w_sftmd  = w_is_r && (bus.Function_opcode[5:3] == 3'b000);
    end

    case (r_state)
      ST_IDLE: begin
        w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        w_mem_req = 1'b1;
        if (bus.mem_ack) begin
          w_ir_write   = 1'b1;
          w_pc_write   = 1'b1;
          w_next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_is_j || w_is_jal) begin
          w_pc_write   = 1'b1;
          w_pc_src     = 2'b10;
          w_jal        = w_is_jal;
          w_regwrite   = w_is_jal;
          w_retire     = 1'b1;
          w_next_state = ST_FETCH;
        end else if (!w_legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          w_next_state = ST_TRAP;
`else
          w_retire     = 1'b1;
          w_next_state = ST_FETCH;
`endif
        end else begin
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (w_is_beq || w_is_bne) begin
          w_pc_write   = w_is_beq ? bus.Zero : ~bus.Zero;
          w_pc_src     = 2'b01;
          w_retire     = 1'b1;
          w_next_state = ST_FETCH;
        end else if (w_is_jr) begin
          w_pc_write   = 1'b1;
          w_pc_src     = 2'b11;
          w_retire     = 1'b1;
          w_next_state = ST_FETCH;
        end else if (w_is_lw || w_is_sw) begin
          w_next_state = ST_MEM;
        end else begin
          w_next_state = ST_WB;
        end
      end
      ST_MEM: begin
        w_mem_req = 1'b1;
        w_mem_we  = w_is_sw;
        if (bus.mem_ack) begin
          w_retire     = w_is_sw;
          w_next_state = w_is_sw ? ST_FETCH : ST_WB;
        end
      end
      ST_WB: begin
        w_regwrite   = 1'b1;
        w_regdst     = w_is_r;
        w_memtoreg   = w_is_lw;
        w_retire     = 1'b1;
        w_next_state = ST_FETCH;
      end
      ST_TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        w_next_state = ST_TRAP;
`else
        w_next_state = ST_IDLE;
`endif
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign bus.mem_req  = w_mem_req;
  assign bus.mem_we   = w_mem_we;
  assign bus.IR_write = w_ir_write;
  assign bus.PC_write = w_pc_write;
  assign bus.pc_src   = w_pc_src;
  assign bus.ALUOp    = w_aluop;
  assign bus.ALUSrc   = w_alusrc;
  assign bus.I_format = w_ifmt;
  assign bus.Sftmd    = w_sftmd;
  assign bus.Jal      = w_jal;
  assign bus.RegDST   = w_regdst;
  assign bus.MemtoReg = w_memtoreg;
  assign bus.RegWrite = w_regwrite;
  assign bus.retire   = w_retire;
  assign bus.state_o  = r_state;

`ifdef CTRL_ILLEGAL_TRAP_EN
  // TRAP only exits through reset, so the state itself is the sticky flag.
  assign bus.illegal_insn = (r_state == ST_TRAP);
`else
  assign bus.illegal_insn = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multicycle_ctrl                                                         |
// | Random instruction stream against a cycle-count model with a scoreboard.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multicycle_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc;
  int   n_vec = 0;
  int   n_bad = 0;
  int   next_start;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct { int cyc; logic [11:0] sig; } ret_t;
  typedef struct { int cyc; logic [2:0]  sig; } ack_t;
  ret_t ret_q[$];
  ack_t ack_q[$];

  function automatic logic [11:0] act_sig();
    return {bus.PC_write, bus.pc_src, bus.RegWrite, bus.RegDST, bus.MemtoReg,
            bus.Jal, bus.ALUOp, bus.ALUSrc, bus.I_format, bus.Sftmd};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected instruction length (FETCH to retire, zero-wait) and retire-cycle controls.
  function automatic void model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                output int lat, output bit mem, output logic [11:0] sig);
    logic       pcw, rw, rd, m2r, jl, asrc, ifm, sft;
    logic [1:0] pcs, aop;
    {pcw, rw, rd, m2r, jl, asrc, ifm, sft} = '0;
    pcs = 2'b00; aop = 2'b00; mem = 1'b0;
    if (op == 6'b000010) begin
      lat = 2; pcw = 1; pcs = 2'b10;
    end else if (op == 6'b000011) begin
      lat = 2; pcw = 1; pcs = 2'b10; jl = 1; rw = 1;
    end else if (op == 6'b000000 && fn == 6'b001000) begin
      lat = 3; pcw = 1; pcs = 2'b11; aop = 2'b10;
    end else if (op == 6'b000100 || op == 6'b000101) begin
      lat = 3; pcs = 2'b01; aop = 2'b01;
      pcw = (op == 6'b000100) ? z : !z;
    end else if (op == 6'b100011) begin
      lat = 5; mem = 1; rw = 1; m2r = 1; asrc = 1;
    end else if (op == 6'b101011) begin
      lat = 4; mem = 1; asrc = 1;
    end else if (op == 6'b000000) begin
      lat = 4; rw = 1; rd = 1; aop = 2'b10; sft = (fn[5:3] == 3'b000);
    end else if (op[5:3] == 3'b001) begin
      lat = 4; rw = 1; aop = 2'b10; asrc = 1; ifm = 1;
    end else begin
      lat = 2;
    end
    sig = {pcw, pcs, rw, rd, m2r, jl, aop, asrc, ifm, sft};
  endfunction

  // Caller sits at posedge+1 of cycle next_start, which is the FETCH cycle.
  task automatic run_batch(input int n);
    logic [5:0] op, fn;
    logic [5:0] bad_ops [4];
    logic       z, is_sw;
    int         k, fw, mw, lat, fack, mack, ret, start;
    bit         mem;
    logic [11:0] sig;
    bad_ops[0] = 6'b111111; bad_ops[1] = 6'b000001;
    bad_ops[2] = 6'b010000; bad_ops[3] = 6'b100000;
    start = next_start;
    for (int i = 0; i < n; i++) begin
      k  = int'($urandom_range(0, 10));
      fn = 6'($urandom);
      if (fn == 6'b001000) fn = 6'b100000;
      case (k)
        1:       begin op = 6'b000000; fn = 6'b001000; end
        2:       op = 6'b000010;
        3:       op = 6'b000011;
        4:       op = 6'b000100;
        5:       op = 6'b000101;
        6:       op = {3'b001, 3'($urandom)};
        7:       op = 6'b100011;
        8:       op = 6'b101011;
`ifdef CTRL_ILLEGAL_TRAP_EN
        10:      op = 6'b000000;
`else
        10:      op = bad_ops[$urandom_range(0, 3)];
`endif
        default: op = 6'b000000;
      endcase
      z  = 1'($urandom);
      fw = int'($urandom_range(0, 2));
      mw = int'($urandom_range(0, 3));
      model(op, fn, z, lat, mem, sig);
      is_sw = (op == 6'b101011);
      fack = start + fw;
      mack = fack + 3 + mw;
      ret  = start + fw + lat - 1 + (mem ? mw : 0);
      ack_q.push_back('{fack, 3'b011});
      if (mem) ack_q.push_back('{mack, {is_sw, 2'b00}});
      ret_q.push_back('{ret, sig});
      for (int c = start; c <= ret; c++) begin
        bus.mem_ack = (c == fack) || (mem && c == mack);
        if (c == fack + 1) begin
          bus.Opcode          = op;
          bus.Function_opcode = fn;
        end
        bus.Zero = (c == fack + 2) ? z : 1'($urandom);
        @(posedge clock); #1;
      end
      start = ret + 1;
    end
    bus.mem_ack = 1'b0;
    next_start  = start;
  endtask

  // Scoreboard monitor: pops on every retire and every accepted memory request.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.retire) begin
        if (ret_q.size() == 0) begin
          check("unexpected_retire", 32'(bus.retire), 32'd0);
        end else begin
          ret_t r;
          r = ret_q.pop_front();
          check("retire_cycle", 32'(cyc), 32'(r.cyc));
          check("retire_ctrl", 32'(act_sig()), 32'(r.sig));
        end
      end
      if (bus.mem_req && bus.mem_ack) begin
        if (ack_q.size() == 0) begin
          check("unexpected_ack", 32'(bus.mem_req), 32'd0);
        end else begin
          ack_t a;
          a = ack_q.pop_front();
          check("ack_cycle", 32'(cyc), 32'(a.cyc));
          check("ack_ctrl", 32'({bus.mem_we, bus.IR_write, bus.PC_write}), 32'(a.sig));
        end
      end
    end
  end

  function automatic logic [20:0] all_out();
    return {bus.mem_req, bus.mem_we, bus.IR_write, bus.retire, bus.illegal_insn,
            bus.state_o, act_sig(), 1'b0};
  endfunction

  initial begin
    bus.mem_ack = 1'b0; bus.Opcode = 6'd0; bus.Function_opcode = 6'd0; bus.Zero = 1'b0;
    next_start = 1;
    repeat (2) @(negedge clock);
    check("reset_outputs", 32'(all_out()), 32'd0);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    run_batch(60);

    // sw stalled in MEM, then reset asserted mid-handshake.
    ack_q.push_back('{next_start, 3'b011});
    bus.mem_ack = 1'b1;
    @(posedge clock); #1;
    bus.mem_ack = 1'b0; bus.Opcode = 6'b101011; bus.Function_opcode = 6'd0;
    repeat (3) begin @(posedge clock); #1; end
    check("sw_mem_req", 32'({bus.mem_req, bus.mem_we, bus.state_o}), 32'({2'b11, 3'd4}));
    #2 reset = 1'b1;
    #1 check("async_reset", 32'(all_out()), 32'd0);
    ret_q.delete(); ack_q.delete();
    @(negedge clock); #1 reset = 1'b0;
    next_start = 1;
    @(posedge clock); #1;
    run_batch(40);

`ifdef CTRL_ILLEGAL_TRAP_EN
    ack_q.push_back('{next_start, 3'b011});
    bus.mem_ack = 1'b1;
    @(posedge clock); #1;
    bus.Opcode = 6'b111111;
    for (int i = 0; i < 6; i++) begin
      bus.mem_ack = 1'($urandom);
      @(posedge clock); #1;
      if (i > 0) check("trap_state", 32'(all_out()), 32'({5'b00001, 3'd6, 12'd0, 1'b0}));
    end
    reset = 1'b1;
    #1 check("trap_cleared", 32'(all_out()), 32'd0);
    @(negedge clock); #1 reset = 1'b0;
    bus.mem_ack = 1'b0;
`endif

    repeat (3) @(posedge clock);
    check("queue_drain", 32'(ret_q.size() + ack_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
